// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide sequencer.
// Holds the FSM state and operation encodings used by muldiv_ctrl.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WRITE,
    DONE
  } muldiv_state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_MULT,
    OP_DIV
  } muldiv_op_t;

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: RUN-cycle counter with limit compare.
// Only instantiated when MULDIV_TIMEOUT_EN is defined.
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = 1048575,
  parameter int CNT_W      = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // count completed RUN cycles; restart on every accepted request
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  // high during the MAX_CYCLES-th RUN cycle
  assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the iterative multiply/divide units into HI/LO.
// Optional watchdog abort is built when MULDIV_TIMEOUT_EN is defined.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = MULDIV_WIDTH,
  parameter int MAX_CYCLES = 1048575,
  parameter int CNT_W      = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             finalMult,
  input  logic             finalDiv,
  input  logic             zeroDiv,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             multControl,
  output logic             divControl,
  output logic             hi_load,
  output logic             lo_load,
  output logic [WIDTH-1:0] hi_in,
  output logic [WIDTH-1:0] lo_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout
);

  if (MAX_CYCLES < 1 ||
      longint'(MAX_CYCLES) >= (longint'(1) << CNT_W))
  begin : g_bad_cfg
    $error("muldiv_ctrl: MAX_CYCLES does not fit CNT_W");
  end

  muldiv_state_t state;
  muldiv_op_t    op;
  logic          accept;
  logic          in_run;
  logic          sel_final;
  logic          expired;

  assign accept = (state == IDLE) && (start_div || start_mult);
  assign in_run = (state == RUN);

  // completion flag of the unit that owns the current operation
  always_comb begin
    sel_final = 1'b0;
    unique case (1'b1)
      op == OP_DIV:  sel_final = finalDiv;
      op == OP_MULT: sel_final = finalMult;
      default:       sel_final = 1'b0;
    endcase
  end

`ifdef MULDIV_TIMEOUT_EN
  muldiv_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_wd (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .run     (in_run),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // sequencer FSM; every output is a register
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      op          <= OP_NONE;
      multControl <= 1'b0;
      divControl  <= 1'b0;
      hi_load     <= 1'b0;
      lo_load     <= 1'b0;
      hi_in       <= '0;
      lo_in       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      hi_load <= 1'b0;
      lo_load <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_div) begin
            op         <= OP_DIV;
            divControl <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end else if (start_mult) begin
            op          <= OP_MULT;
            multControl <= 1'b1;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (sel_final) begin
            multControl <= 1'b0;
            divControl  <= 1'b0;
            hi_load     <= 1'b1;
            lo_load     <= 1'b1;
            if (op == OP_DIV) begin
              hi_in <= div_hi;
              lo_in <= div_lo;
            end else begin
              hi_in <= mult_hi;
              lo_in <= mult_lo;
            end
            div_zero <= (op == OP_DIV) && zeroDiv;
            state    <= WRITE;
          end else if (expired) begin
            multControl <= 1'b0;
            divControl  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            state       <= DONE;
          end
        end
        WRITE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          div_zero <= 1'b0;
          timeout  <= 1'b0;
          op       <= OP_NONE;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized self-checking bench for muldiv_ctrl.
// Build with MULDIV_TIMEOUT_EN to also exercise the watchdog path.
module tb_muldiv_ctrl;

  localparam int W    = 32;
  localparam int MAXC = 8;
`ifdef MULDIV_TIMEOUT_EN
  localparam int MAXLAT = MAXC;
`else
  localparam int MAXLAT = 20;
`endif
  localparam int LAT15 = (MAXLAT < 15) ? MAXLAT : 15;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_mult, start_div;
  logic         finalMult, finalDiv, zeroDiv;
  logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic         multControl, divControl;
  logic         hi_load, lo_load;
  logic [W-1:0] hi_in, lo_in;
  logic         busy, done, div_zero, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  muldiv_ctrl #(
    .WIDTH      (W),
    .MAX_CYCLES (MAXC),
    .CNT_W      (20)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .finalMult   (finalMult),
    .finalDiv    (finalDiv),
    .zeroDiv     (zeroDiv),
    .mult_hi     (mult_hi),
    .mult_lo     (mult_lo),
    .div_hi      (div_hi),
    .div_lo      (div_lo),
    .multControl (multControl),
    .divControl  (divControl),
    .hi_load     (hi_load),
    .lo_load     (lo_load),
    .hi_in       (hi_in),
    .lo_in       (lo_in),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .timeout     (timeout)
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // flags = {multControl,divControl,hi_load,lo_load,
  //          busy,done,div_zero,timeout}
  task automatic chk_flags(input string tag,
                           input logic [7:0] exp);
    chk(tag, {24'b0, multControl, divControl, hi_load,
              lo_load, busy, done, div_zero, timeout},
        {24'b0, exp});
  endtask

  // garbage on unit outputs; the owning unit is not finished
  task automatic scramble(input bit is_div);
    mult_hi = $urandom;
    mult_lo = $urandom;
    div_hi  = $urandom;
    div_lo  = $urandom;
    zeroDiv = 1'($urandom);
    if (is_div) begin
      finalDiv  = 1'b0;
      finalMult = 1'($urandom);
    end else begin
      finalMult = 1'b0;
      finalDiv  = 1'($urandom);
    end
  endtask

  task automatic set_starts(input bit noisy);
    start_mult = noisy ? 1'($urandom) : 1'b0;
    start_div  = noisy ? 1'($urandom) : 1'b0;
  endtask

  // called at a negedge with the DUT idle; returns at the
  // negedge of the first cycle a new start may be accepted
  task automatic do_op(input bit is_div, input bit both,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input int lat, input bit zero,
                       input bit noisy);
    logic [W-1:0]   eh, el;
    logic [2*W-1:0] p;
    logic           ez;
    if (is_div) begin
      if (zero) begin
        eh = 32'h7FFF_FFFF;
        el = 32'h7FFF_FFFF;
      end else begin
        eh = a % b;
        el = a / b;
      end
    end else begin
      p  = {32'b0, a} * {32'b0, b};
      eh = p[2*W-1:W];
      el = p[W-1:0];
    end
    ez = is_div && zero;
    start_div  = is_div;
    start_mult = !is_div || both;
    scramble(is_div);
    @(negedge clock);
    for (int k = 1; k <= lat; k++) begin
      chk_flags("run", is_div ? 8'b0100_1000
                              : 8'b1000_1000);
      set_starts(noisy);
      scramble(is_div);
      if (k == lat) begin
        if (is_div) begin
          finalDiv = 1'b1;
          zeroDiv  = zero;
          div_hi   = eh;
          div_lo   = el;
        end else begin
          finalMult = 1'b1;
          mult_hi   = eh;
          mult_lo   = el;
        end
      end
      @(negedge clock);
    end
    chk_flags("write", {4'b0011, 1'b1, 1'b0, ez, 1'b0});
    chk("hi_in", hi_in, eh);
    chk("lo_in", lo_in, el);
    set_starts(noisy);
    scramble(is_div);
    @(negedge clock);
    chk_flags("done", {5'b00000, 1'b1, ez, 1'b0});
    set_starts(noisy);
    scramble(is_div);
    @(negedge clock);
    chk_flags("idle", 8'b0);
    set_starts(1'b0);
    finalDiv  = 1'b0;
    finalMult = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    bit           d, z;
    int           lat;

    reset = 1'b1;
    set_starts(1'b0);
    finalMult = 1'b0;
    finalDiv  = 1'b0;
    zeroDiv   = 1'b0;
    mult_hi   = '0;
    mult_lo   = '0;
    div_hi    = '0;
    div_lo    = '0;
    @(negedge clock);
    @(negedge clock);
    chk_flags("reset_flags", 8'b0);
    chk("reset_hi", hi_in, '0);
    chk("reset_lo", lo_in, '0);
    reset = 1'b0;
    @(negedge clock);
    chk_flags("post_reset", 8'b0);

    // 100 / 7 -> rem 2, quo 14
    do_op(1'b1, 1'b0, 32'd100, 32'd7, LAT15, 1'b0, 1'b0);
    // divide by zero flagged in first RUN cycle
    do_op(1'b1, 1'b0, 32'd55, 32'd0, 1, 1'b1, 1'b0);
    // simultaneous starts plus noisy starts while busy
    do_op(1'b1, 1'b1, 32'd1000, 32'd33, 5, 1'b0, 1'b1);
    @(negedge clock);
    chk_flags("no_second_op", 8'b0);
    // back-to-back divides
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3, 3, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 32'd12345, 32'd100, 2, 1'b0, 1'b0);
    // multiply with latency 1
    do_op(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1,
          1'b0, 1'b0);

    // reset in the middle of RUN
    start_div = 1'b1;
    @(negedge clock);
    start_div = 1'b0;
    repeat (3) begin
      chk_flags("pre_abort_run", 8'b0100_1000);
      @(negedge clock);
    end
    reset    = 1'b1;
    finalDiv = 1'b1;
    div_hi   = 32'hAAAA_AAAA;
    div_lo   = 32'h5555_5555;
    @(negedge clock);
    chk_flags("abort_flags", 8'b0);
    chk("abort_hi", hi_in, '0);
    chk("abort_lo", lo_in, '0);
    reset    = 1'b0;
    finalDiv = 1'b0;
    @(negedge clock);
    chk_flags("abort_idle", 8'b0);
    do_op(1'b0, 1'b0, 32'd7, 32'd9, 4, 1'b0, 1'b0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom);
      a = $urandom;
      b = $urandom;
      z = d && ($urandom_range(0, 3) == 0);
      if (z) b = '0;
      else if (b == '0) b = 32'd1;
      lat = z ? 1 : int'($urandom_range(1, MAXLAT));
      do_op(d, 1'($urandom), a, b, lat, z, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clock);
        chk_flags("gap", 8'b0);
      end
    end

`ifdef MULDIV_TIMEOUT_EN
    // unit that never finishes
    start_mult = 1'b1;
    scramble(1'b0);
    @(negedge clock);
    set_starts(1'b0);
    for (int k = 1; k <= MAXC; k++) begin
      chk_flags("wd_run", 8'b1000_1000);
      scramble(1'b0);
      @(negedge clock);
    end
    chk_flags("wd_done", 8'b0000_0101);
    scramble(1'b0);
    @(negedge clock);
    chk_flags("wd_idle", 8'b0);
    finalDiv = 1'b0;
    do_op(1'b1, 1'b0, 32'd81, 32'd9, MAXC, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer that sits between the CPU control unit and the iterative multiply and divide units. It accepts single-cycle start requests and drives the selected unit's control line until that unit reports completion. It then writes the unit's results into the HI/LO registers through load-enable pulses and reports completion, divide-by-zero and optional timeout to the control unit. While an operation is in flight it holds `busy` high so the control unit can stall.

## Interface
- `WIDTH`, 32: data width of the HI/LO result paths.
- `MAX_CYCLES`, 1048575: watchdog limit on the number of RUN cycles. Used only when `MULDIV_TIMEOUT_EN` is defined.
- `CNT_W`, 20: width of the watchdog counter. Must satisfy `MAX_CYCLES` < 2^`CNT_W`.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start_mult`, in, 1: one-cycle request to start a multiply.
- `start_div`, in, 1: one-cycle request to start a divide.
- `finalMult`, in, 1: multiplier done flag.
- `finalDiv`, in, 1: divider done flag.
- `zeroDiv`, in, 1: divider divide-by-zero flag.
- `mult_hi`, `mult_lo`, in, `WIDTH`: multiplier results.
- `div_hi`, `div_lo`, in, `WIDTH`: divider results (remainder and quotient).
- `multControl`, out, 1: multiplier run enable.
- `divControl`, out, 1: divider run enable.
- `hi_load`, `lo_load`, out, 1: HI/LO register write enables.
- `hi_in`, `lo_in`, out, `WIDTH`: data for the HI/LO registers.
- `busy`, out, 1: operation in flight; the control unit must stall.
- `done`, out, 1: one-cycle completion pulse.
- `div_zero`, out, 1: divide-by-zero flag, valid with `done`.
- `timeout`, out, 1: watchdog abort flag, valid with `done`.

## Operation
- States: IDLE, RUN, WRITE, DONE. All outputs are registered.
- IDLE:
  - If `start_div` is sampled high: op := DIV, go to RUN.
  - Else if `start_mult` is sampled high: op := MULT, go to RUN.
  - If both are high in the same cycle, divide wins and the multiply request is dropped.
- RUN:
  - Drive `divControl` or `multControl` (only the one matching op) high continuously.
  - Start requests arriving in RUN, WRITE or DONE are ignored; they are not queued.
- RUN → WRITE when the selected unit's `final*` is sampled high. The other unit's `final*` is ignored. In WRITE:
  - Capture the selected unit's hi/lo into `hi_in`/`lo_in`.
  - Pulse `hi_load` and `lo_load` for one cycle.
  - Drop the control line.
  - Latch `div_zero` := `zeroDiv` if op = DIV, else 0.
- On divide-by-zero the divider's saturated results are still written to HI/LO; `div_zero` is purely informational.
- WRITE → DONE: pulse `done` for one cycle; `div_zero` and `timeout` are held valid during this cycle.
- DONE → IDLE unconditionally.
  - The DONE cycle guarantees the control line is low for at least 2 cycles between operations. This is required so each unit re-arms its initial-load step.
- Reset at any point: IDLE next cycle, all outputs 0, no HI/LO write for the aborted operation.
- Reset values: `multControl`, `divControl`, `hi_load`, `lo_load`, `busy`, `done`, `div_zero` and `timeout` are 0; `hi_in` and `lo_in` are 0.

## Timing
- Start sampled in cycle N. The control line and `busy` go high at N+1.
- `final*` sampled high in cycle M (M ≥ N+1):
  - M+1: `hi_load`/`lo_load` high, control low.
  - M+2: `done` high, `busy` low.
  - Earliest next accepted start: M+3.
- `busy` is high from N+1 through M+1 inclusive. `busy` and `done` are never high in the same cycle.
- A divide-by-zero (unit flags final in its first cycle) completes with `done` at N+3.

## Configuration
- `MULDIV_TIMEOUT_EN` defined:
  - A CNT_W-bit counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches `MAX_CYCLES` without `final*`: go directly to DONE, drop control, do not pulse `hi_load`/`lo_load`, and pulse `done` with `timeout` = 1.
  - If `final*` and the limit occur in the same cycle, `final*` wins (normal WRITE path).
- `MULDIV_TIMEOUT_EN` undefined: no counter is present, `timeout` is tied to 0, and RUN waits for `final*` indefinitely.

## Structure
- Shared package `muldiv_pkg` holds:
  - `muldiv_state_t` (IDLE, RUN, WRITE, DONE).
  - `muldiv_op_t` (OP_NONE, OP_MULT, OP_DIV).
  - The `MULDIV_WIDTH` = 32 constant.
- One sub-module, `muldiv_watchdog` (counter plus limit compare), instantiated only under `MULDIV_TIMEOUT_EN`.

## Test plan
- `start_div` with unit model 100 / 7 finishing 15 cycles later → `divControl` high 15 cycles. Then `hi_in`=2 and `lo_in`=14 with the load pulses, then `done` with `div_zero`=0.
- `start_div` with the model flagging zero in its first cycle → `hi_in`=`lo_in`=0x7FFFFFFF written, `done` at N+3 with `div_zero`=1.
- `start_mult` and `start_div` in the same cycle → only `divControl` asserts. A `start_mult` issued during RUN produces no second operation.
- Two back-to-back divides → `divControl` is low for ≥2 cycles between them and both results are written.
- `reset` asserted mid-RUN → all outputs 0 next cycle, no `hi_load`, and a new start is accepted afterwards.
- With `MULDIV_TIMEOUT_EN` and `MAX_CYCLES`=8, a unit that never finishes → `done` and `timeout` pulse after 8 RUN cycles, with no load pulses.
